// File: rtl/ibex_rf_wb_arbiter_if.sv
// ibex_rf_wb_arbiter_if
//   Bundles the writeback-arbiter handshake and bus signals.
//   slave  : the arbiter (consumes EX/LSU requests and ID read addresses,
//            drives readies, the register-file write port and hazard/held).
//   master : the environment (EX, LSU, ID and the register file).
//   Signals:
//     ex_valid_i/ex_waddr_i/ex_wdata_i/ex_ready_o     EX write request
//     lsu_valid_i/lsu_waddr_i/lsu_wdata_i/lsu_ready_o LSU write request
//     rf_we_o/rf_waddr_o/rf_wdata_o                   register-file write port
//     raddr_a_i/raddr_b_i                             ID read addresses
//     hazard_o                                        read hits the parked write
//     held_o                                          holding buffer occupied
//   With IBEX_WB_ARB_STATS_EN defined, ex_stall_cnt_o and lsu_stall_cnt_o
//   are added.
interface ibex_rf_wb_arbiter_if #(
   parameter int unsigned DataWidth = 32
);
   logic                 ex_valid_i;
   logic [4:0]           ex_waddr_i;
   logic [DataWidth-1:0] ex_wdata_i;
   logic                 ex_ready_o;
   logic                 lsu_valid_i;
   logic [4:0]           lsu_waddr_i;
   logic [DataWidth-1:0] lsu_wdata_i;
   logic                 lsu_ready_o;
   logic                 rf_we_o;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;
   logic [4:0]           raddr_a_i;
   logic [4:0]           raddr_b_i;
   logic                 hazard_o;
   logic                 held_o;
`ifdef IBEX_WB_ARB_STATS_EN
   logic [31:0]          ex_stall_cnt_o;
   logic [31:0]          lsu_stall_cnt_o;
`endif

   modport slave (
      input  ex_valid_i, ex_waddr_i, ex_wdata_i,
      input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      input  raddr_a_i, raddr_b_i,
      output ex_ready_o, lsu_ready_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o,
`ifdef IBEX_WB_ARB_STATS_EN
      output ex_stall_cnt_o, lsu_stall_cnt_o,
`endif
      output hazard_o, held_o
   );

   modport master (
      output ex_valid_i, ex_waddr_i, ex_wdata_i,
      output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      output raddr_a_i, raddr_b_i,
      input  ex_ready_o, lsu_ready_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o,
`ifdef IBEX_WB_ARB_STATS_EN
      input  ex_stall_cnt_o, lsu_stall_cnt_o,
`endif
      input  hazard_o, held_o
   );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter
//   Shares the single register-file write port between EX and LSU writeback.
//   LSU wins; a losing EX write is parked in a one-entry buffer and drained
//   when LSU is idle. A hold counter bounds starvation: once the parked entry
//   has lost MaxHold times in a row, LSU is back-pressured for one cycle so the
//   entry drains. hazard_o lets ID stall reads of the parked register.
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     ibex_rf_wb_arbiter_if.slave (requests, write port, hazard)
//   Parameters: RV32E (16 registers, address bit 4 ignored), DataWidth,
//   MaxHold (1..15).
//   Optional: define IBEX_WB_ARB_STATS_EN to add saturating EX/LSU stall
//   counters on the interface.
module ibex_rf_wb_arbiter #(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxHold   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   ibex_rf_wb_arbiter_if.slave     bus
);

   // In RV32E the top address bit is dropped everywhere, so x16..x31 alias
   // x0..x15 (including the x0 "no write" rule).
   localparam logic [4:0] ADDR_MASK = RV32E ? 5'h0F : 5'h1F;
   localparam logic [3:0] HOLD_MAX  = 4'(MaxHold);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HELD  = 1'b1
   } state_e;

   state_e               r_state;
   logic [3:0]           r_hold_cnt;
   logic [4:0]           r_buf_addr;
   logic [DataWidth-1:0] r_buf_data;

   logic [4:0]           w_ex_addr;
   logic [4:0]           w_lsu_addr;
   logic [4:0]           w_ra;
   logic [4:0]           w_rb;
   logic                 w_held;
   logic                 w_ex_ready;
   logic                 w_lsu_ready;
   logic                 w_lsu_fire;
   logic                 w_held_fire;
   logic                 w_ex_fire;
   logic                 w_capture;
   logic [4:0]           w_gnt_addr;
   logic [DataWidth-1:0] w_gnt_data;

   assign w_ex_addr  = bus.ex_waddr_i  & ADDR_MASK;
   assign w_lsu_addr = bus.lsu_waddr_i & ADDR_MASK;
   assign w_ra       = bus.raddr_a_i   & ADDR_MASK;
   assign w_rb       = bus.raddr_b_i   & ADDR_MASK;

   assign w_held      = (r_state == S_HELD);
   assign w_ex_ready  = !w_held;
   assign w_lsu_ready = !(w_held && (r_hold_cnt == HOLD_MAX));

   // Grant priority: LSU, then the parked entry, then a fresh EX request.
   assign w_lsu_fire  = bus.lsu_valid_i & w_lsu_ready;
   assign w_held_fire = !w_lsu_fire & w_held;
   assign w_ex_fire   = !w_lsu_fire & !w_held & bus.ex_valid_i;

   // EX loses to LSU: park it, unless it targets x0 (handshake only).
   assign w_capture = !w_held & bus.ex_valid_i & w_lsu_fire & (w_ex_addr != 5'd0);

   always_comb begin
      w_gnt_addr = 5'd0;
      w_gnt_data = '0;
      if (w_lsu_fire) begin
         w_gnt_addr = w_lsu_addr;
         w_gnt_data = bus.lsu_wdata_i;
      end else if (w_held_fire) begin
         w_gnt_addr = r_buf_addr;
         w_gnt_data = r_buf_data;
      end else if (w_ex_fire) begin
         w_gnt_addr = w_ex_addr;
         w_gnt_data = bus.ex_wdata_i;
      end
   end

   assign bus.ex_ready_o  = w_ex_ready;
   assign bus.lsu_ready_o = w_lsu_ready;
   assign bus.rf_waddr_o  = w_gnt_addr;
   assign bus.rf_wdata_o  = w_gnt_data;
   assign bus.rf_we_o     = (w_lsu_fire | w_held_fire | w_ex_fire) & (w_gnt_addr != 5'd0);
   assign bus.held_o      = w_held;
   // The buffer never holds x0, but guard anyway so x0 can never hazard.
   assign bus.hazard_o    = w_held & (r_buf_addr != 5'd0) &
                            ((w_ra == r_buf_addr) | (w_rb == r_buf_addr));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_EMPTY;
         r_hold_cnt <= 4'd0;
         r_buf_addr <= 5'd0;
         r_buf_data <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_capture) begin
                  r_state    <= S_HELD;
                  r_buf_addr <= w_ex_addr;
                  r_buf_data <= bus.ex_wdata_i;
                  r_hold_cnt <= 4'd0;
               end
            end
            S_HELD: begin
               // Any cycle the entry is not drained, it lost to LSU.
               if (w_lsu_fire) begin
                  r_hold_cnt <= r_hold_cnt + 4'd1;
               end else begin
                  r_state    <= S_EMPTY;
                  r_hold_cnt <= 4'd0;
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

`ifdef IBEX_WB_ARB_STATS_EN
   logic [31:0] r_ex_stall_cnt;
   logic [31:0] r_lsu_stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ex_stall_cnt  <= 32'd0;
         r_lsu_stall_cnt <= 32'd0;
      end else begin
         if (bus.ex_valid_i && !w_ex_ready && (r_ex_stall_cnt != 32'hFFFF_FFFF))
            r_ex_stall_cnt <= r_ex_stall_cnt + 32'd1;
         if (bus.lsu_valid_i && !w_lsu_ready && (r_lsu_stall_cnt != 32'hFFFF_FFFF))
            r_lsu_stall_cnt <= r_lsu_stall_cnt + 32'd1;
      end
   end

   assign bus.ex_stall_cnt_o  = r_ex_stall_cnt;
   assign bus.lsu_stall_cnt_o = r_lsu_stall_cnt;
`endif

endmodule
